// File: rtl/ex_wb_stage.sv
// ex_wb_stage: two-entry skid FIFO between the ALU and the register-file write port, with forwarding of the youngest entry
//   clock_in, reset_in (async, active-high)
//   upstream   : valid_in / ready_out, result_in, rd_addr_in, wb_en_in, flush_in
//   write-back : valid_out / ready_in, wb_data_out, wb_addr_out, wb_en_out
//   forwarding : fwd_valid_out, fwd_addr_out, fwd_data_out
//   status     : count_out (0..2)
module ex_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock_in,
    input  logic                      reset_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [DATA_WIDTH-1:0]     result_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                      wb_en_in,
    input  logic                      flush_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [DATA_WIDTH-1:0]     wb_data_out,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr_out,
    output logic                      wb_en_out,
    output logic                      fwd_valid_out,
    output logic [REG_ADDR_WIDTH-1:0] fwd_addr_out,
    output logic [DATA_WIDTH-1:0]     fwd_data_out,
    output logic [1:0]                count_out
);
    logic [1:0]                count;
    logic [DATA_WIDTH-1:0]     head_data, tail_data, y_data;
    logic [REG_ADDR_WIDTH-1:0] head_rd, tail_rd, y_rd;
    logic                      head_we, tail_we, y_we;
    logic                      push, pop, head_load, head_shift, tail_load;
    assign ready_out  = count != 2'd2;
    assign valid_out  = count != 2'd0;
    assign push       = valid_in & ready_out & ~flush_in;
    assign pop        = valid_out & ready_in;
    // incoming result goes straight to the head when it is (or is about to be) empty
    assign head_load  = push & (count == 2'd0 | (count == 2'd1 & pop));
    assign head_shift = pop & count == 2'd2;
    assign tail_load  = push & count == 2'd1 & ~pop;
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            count     <= '0;
            head_data <= '0;
            head_rd   <= '0;
            head_we   <= 1'b0;
            tail_data <= '0;
            tail_rd   <= '0;
            tail_we   <= 1'b0;
        end else begin
            count <= flush_in ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
            if (head_load) begin
                head_data <= result_in;
                head_rd   <= rd_addr_in;
                head_we   <= wb_en_in;
            end else if (head_shift) begin
                head_data <= tail_data;
                head_rd   <= tail_rd;
                head_we   <= tail_we;
            end
            if (tail_load) begin
                tail_data <= result_in;
                tail_rd   <= rd_addr_in;
                tail_we   <= wb_en_in;
            end
        end
    end
    assign count_out     = count;
    assign wb_data_out   = head_data;
    assign wb_addr_out   = head_rd;
    assign wb_en_out     = valid_out & head_we & (head_rd != '0);
    assign y_data        = count == 2'd2 ? tail_data : head_data;
    assign y_rd          = count == 2'd2 ? tail_rd : head_rd;
    assign y_we          = count == 2'd2 ? tail_we : head_we;
    assign fwd_valid_out = valid_out & y_we & (y_rd != '0);
    assign fwd_addr_out  = fwd_valid_out ? y_rd : '0;
    assign fwd_data_out  = fwd_valid_out ? y_data : '0;
endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: directed self-checking bench for ex_wb_stage
module tb_ex_wb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0, ready_in = 1'b0, wb_en_in = 1'b0, flush_in = 1'b0;
    logic [31:0] result_in = '0;
    logic [4:0]  rd_addr_in = '0;
    logic        ready_out, valid_out, wb_en_out, fwd_valid_out;
    logic [31:0] wb_data_out, fwd_data_out;
    logic [4:0]  wb_addr_out, fwd_addr_out;
    logic [1:0]  count_out;
    int          vectors = 0, miscompares = 0;
    ex_wb_stage dut (
        .clock_in(clk), .reset_in(rst),
        .valid_in(valid_in), .ready_out(ready_out),
        .result_in(result_in), .rd_addr_in(rd_addr_in), .wb_en_in(wb_en_in),
        .flush_in(flush_in),
        .valid_out(valid_out), .ready_in(ready_in),
        .wb_data_out(wb_data_out), .wb_addr_out(wb_addr_out), .wb_en_out(wb_en_out),
        .fwd_valid_out(fwd_valid_out), .fwd_addr_out(fwd_addr_out), .fwd_data_out(fwd_data_out),
        .count_out(count_out)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic we);
        valid_in   = v;
        result_in  = d;
        rd_addr_in = rd;
        wb_en_in   = we;
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, " count"}, 32'(count_out), 0);
        chk({tag, " ready"}, 32'(ready_out), 1);
        chk({tag, " valid"}, 32'(valid_out), 0);
        chk({tag, " wb_data"}, wb_data_out, 0);
        chk({tag, " wb_addr"}, 32'(wb_addr_out), 0);
        chk({tag, " wb_en"}, 32'(wb_en_out), 0);
        chk({tag, " fwd_valid"}, 32'(fwd_valid_out), 0);
        chk({tag, " fwd_addr"}, 32'(fwd_addr_out), 0);
        chk({tag, " fwd_data"}, fwd_data_out, 0);
    endtask
    initial begin
        #2;
        chk_reset_outputs("rst0");
        step();
        rst = 1'b0;
        // single pass
        ready_in = 1'b1;
        drive(1, 32'h0000_00FF, 5, 1);
        step();
        drive(0, 0, 0, 0);
        chk("sp valid", 32'(valid_out), 1);
        chk("sp data", wb_data_out, 32'hFF);
        chk("sp addr", 32'(wb_addr_out), 5);
        chk("sp wb_en", 32'(wb_en_out), 1);
        chk("sp fwd_valid", 32'(fwd_valid_out), 1);
        chk("sp fwd_data", fwd_data_out, 32'hFF);
        chk("sp count", 32'(count_out), 1);
        step();
        chk("sp drained", 32'(valid_out), 0);
        // backpressure
        ready_in = 1'b0;
        drive(1, 32'h11, 1, 1);
        step();
        drive(1, 32'h22, 2, 1);
        step();
        chk("bp count", 32'(count_out), 2);
        chk("bp ready", 32'(ready_out), 0);
        chk("bp head", wb_data_out, 32'h11);
        chk("bp head addr", 32'(wb_addr_out), 1);
        chk("bp fwd_addr", 32'(fwd_addr_out), 2);
        chk("bp fwd_data", fwd_data_out, 32'h22);
        drive(1, 32'h55, 7, 1);
        step();
        drive(0, 0, 0, 0);
        chk("bp full count", 32'(count_out), 2);
        chk("bp hold head", wb_data_out, 32'h11);
        chk("bp hold fwd", fwd_data_out, 32'h22);
        ready_in = 1'b1;
        step();
        chk("bp pop1 data", wb_data_out, 32'h22);
        chk("bp pop1 addr", 32'(wb_addr_out), 2);
        chk("bp pop1 count", 32'(count_out), 1);
        step();
        chk("bp pop2 count", 32'(count_out), 0);
        // streaming
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + 32'(i), 5'(i + 1), 1);
            step();
            chk($sformatf("st%0d count", i), 32'(count_out), 1);
            chk($sformatf("st%0d data", i), wb_data_out, 32'h100 + 32'(i));
            chk($sformatf("st%0d addr", i), 32'(wb_addr_out), i + 1);
        end
        drive(0, 0, 0, 0);
        step();
        chk("st drained", 32'(count_out), 0);
        // x0 write
        ready_in = 1'b0;
        drive(1, 32'hDEAD_BEEF, 0, 1);
        step();
        drive(0, 0, 0, 0);
        chk("x0 valid", 32'(valid_out), 1);
        chk("x0 data", wb_data_out, 32'hDEAD_BEEF);
        chk("x0 wb_en", 32'(wb_en_out), 0);
        chk("x0 fwd_valid", 32'(fwd_valid_out), 0);
        chk("x0 fwd_data", fwd_data_out, 0);
        ready_in = 1'b1;
        step();
        chk("x0 popped", 32'(count_out), 0);
        // wb_en=0 entry
        drive(1, 32'h77, 9, 0);
        ready_in = 1'b0;
        step();
        drive(0, 0, 0, 0);
        chk("noen wb_en", 32'(wb_en_out), 0);
        chk("noen fwd_valid", 32'(fwd_valid_out), 0);
        chk("noen count", 32'(count_out), 1);
        // flush with pending push at count=2
        drive(1, 32'h33, 3, 1);
        step();
        chk("fl full", 32'(count_out), 2);
        drive(1, 32'h99, 9, 1);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        drive(0, 0, 0, 0);
        chk("fl count", 32'(count_out), 0);
        chk("fl valid", 32'(valid_out), 0);
        chk("fl ready", 32'(ready_out), 1);
        chk("fl fwd_valid", 32'(fwd_valid_out), 0);
        ready_in = 1'b1;
        step();
        chk("fl stays empty", 32'(valid_out), 0);
        chk("fl no 99 fwd", fwd_data_out, 0);
        // flush concurrent with a pop at count=1
        drive(1, 32'hAA, 10, 1);
        step();
        drive(0, 0, 0, 0);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("flpop count", 32'(count_out), 0);
        // async reset at count=2
        ready_in = 1'b0;
        drive(1, 32'h1234, 4, 1);
        step();
        drive(1, 32'h5678, 6, 1);
        step();
        drive(0, 0, 0, 0);
        chk("ar pre count", 32'(count_out), 2);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("ar");
        step();
        rst = 1'b0;
        step();
        chk("ar after", 32'(count_out), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
